// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle sequencer and the RV32I datapath.
// The controller is the master; the datapath drives the IR fields, Z and mem_ready.
interface mc_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Z;
    logic       mem_ready;
    logic       mem_req;
    logic       dmem_write;
    logic       adr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       regfile_wren;
    logic [1:0] alu_srca_sel;
    logic [1:0] alu_srcb_sel;
    logic [1:0] result_sel;
    logic [1:0] ximm_sel;
    logic [2:0] ALU_control;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  opcode, funct3, funct7b5, Z, mem_ready,
        output mem_req, dmem_write, adr_sel, ir_write, pc_write, regfile_wren,
               alu_srca_sel, alu_srcb_sel, result_sel, ximm_sel, ALU_control,
               trap, trap_cause
    );

    modport slave (
        output opcode, funct3, funct7b5, Z, mem_ready,
        input  mem_req, dmem_write, adr_sel, ir_write, pc_write, regfile_wren,
               alu_srca_sel, alu_srcb_sel, result_sel, ximm_sel, ALU_control,
               trap, trap_cause
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle sequencer for the RV32I subset (R/I-ALU, lw, sw, beq, jal) with a
// bounded memory handshake; outputs are decoded from state and gated off by reset.
module mc_controller #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic      clk,
    input logic      reset,
    mc_controller_if.master bus
);
    localparam int              CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       cause, cause_nxt;
    logic             mem_wait, at_last, f3_ok;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        case (f3)
            3'b000:  alu_decode = sub_en ? 3'b001 : 3'b000;
            3'b010:  alu_decode = 3'b101;
            3'b110:  alu_decode = 3'b011;
            3'b111:  alu_decode = 3'b010;
            default: alu_decode = 3'b000;
        endcase
    endfunction

    assign mem_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign at_last  = (wait_cnt == CNT_LAST);
    assign f3_ok    = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);

    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        case (state)
            S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                if (bus.mem_ready) begin
                    case (state)
                        S_FETCH:   state_nxt = S_DECODE;
                        S_MEMREAD: state_nxt = S_MEMWB;
                        default:   state_nxt = S_FETCH;
                    endcase
                end else if (at_last) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                state_nxt = S_TRAP;
                cause_nxt = CAUSE_ILLEGAL;
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
                    state_nxt = S_MEMADR;
                    cause_nxt = cause;
                end else if (bus.opcode == OP_R && f3_ok) begin
                    state_nxt = S_EXECR;
                    cause_nxt = cause;
                end else if (bus.opcode == OP_I && f3_ok) begin
                    state_nxt = S_EXECI;
                    cause_nxt = cause;
                end else if (bus.opcode == OP_BEQ) begin
                    state_nxt = S_BEQ;
                    cause_nxt = cause;
                end else if (bus.opcode == OP_JAL) begin
                    state_nxt = S_JAL;
                    cause_nxt = cause;
                end
            end
            S_MEMADR:                state_nxt = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL: state_nxt = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: state_nxt = S_FETCH;
            S_TRAP:                  state_nxt = S_TRAP;
            default:                 state_nxt = S_FETCH;
        endcase
    end

    // Reset gates every output so nothing issued mid-handshake survives it.
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.dmem_write   = 1'b0;
        bus.adr_sel      = 1'b0;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.regfile_wren = 1'b0;
        bus.alu_srca_sel = 2'b00;
        bus.alu_srcb_sel = 2'b00;
        bus.result_sel   = 2'b00;
        bus.ximm_sel     = 2'b00;
        bus.ALU_control  = 3'b000;
        bus.trap         = 1'b0;
        bus.trap_cause   = 2'b00;
        if (!reset) begin
            case (bus.opcode)
                OP_SW:   bus.ximm_sel = 2'b01;
                OP_BEQ:  bus.ximm_sel = 2'b10;
                OP_JAL:  bus.ximm_sel = 2'b11;
                default: bus.ximm_sel = 2'b00;
            endcase
            case (state)
                S_FETCH: begin
                    bus.mem_req      = 1'b1;
                    bus.ir_write     = bus.mem_ready;
                    bus.pc_write     = bus.mem_ready;
                    bus.alu_srcb_sel = 2'b10;
                    bus.result_sel   = 2'b10;
                end
                S_DECODE: begin
                    bus.alu_srca_sel = 2'b01;
                    bus.alu_srcb_sel = 2'b01;
                end
                S_MEMADR: begin
                    bus.alu_srca_sel = 2'b10;
                    bus.alu_srcb_sel = 2'b01;
                end
                S_MEMREAD: begin
                    bus.mem_req = 1'b1;
                    bus.adr_sel = 1'b1;
                end
                S_MEMWB: begin
                    bus.result_sel   = 2'b01;
                    bus.regfile_wren = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.mem_req    = 1'b1;
                    bus.dmem_write = 1'b1;
                    bus.adr_sel    = 1'b1;
                end
                S_EXECR: begin
                    bus.alu_srca_sel = 2'b10;
                    bus.ALU_control  = alu_decode(bus.funct3, bus.funct7b5);
                end
                S_EXECI: begin
                    bus.alu_srca_sel = 2'b10;
                    bus.alu_srcb_sel = 2'b01;
                    bus.ALU_control  = alu_decode(bus.funct3, 1'b0);
                end
                S_ALUWB: bus.regfile_wren = 1'b1;
                S_BEQ: begin
                    bus.alu_srca_sel = 2'b10;
                    bus.ALU_control  = 3'b001;
                    bus.pc_write     = bus.Z;
                end
                S_JAL: begin
                    bus.alu_srca_sel = 2'b01;
                    bus.alu_srcb_sel = 2'b10;
                    bus.pc_write     = 1'b1;
                end
                S_TRAP: begin
                    bus.trap       = 1'b1;
                    bus.trap_cause = cause;
                end
                default: ;
            endcase
        end
    end

    // Wait counter restarts on every state change and saturates at its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            cause    <= 2'b00;
        end else begin
            state <= state_nxt;
            cause <= cause_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (mem_wait && !bus.mem_ready && !at_last)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller with TIMEOUT_CYCLES=4; every output is
// checked as one packed control word against hand-built expectations.
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_controller_if bus();
    mc_controller #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic [19:0] obs;
    assign obs = {bus.mem_req, bus.dmem_write, bus.adr_sel, bus.ir_write, bus.pc_write,
                  bus.regfile_wren, bus.alu_srca_sel, bus.alu_srcb_sel, bus.result_sel,
                  bus.ximm_sel, bus.ALU_control, bus.trap, bus.trap_cause};

    int checks = 0;
    int errors = 0;

    // Field order: mem_req dmem_write adr_sel ir_write pc_write regfile_wren srcA srcB result ximm alu trap cause
    function automatic logic [19:0] ctrl(input int mr, input int dw, input int ad, input int iw,
                                         input int pw, input int rw, input int sa, input int sb,
                                         input int rs, input int xs, input int alu, input int tr,
                                         input int tc);
        return {1'(mr), 1'(dw), 1'(ad), 1'(iw), 1'(pw), 1'(rw), 2'(sa), 2'(sb), 2'(rs),
                2'(xs), 3'(alu), 1'(tr), 2'(tc)};
    endfunction

    function automatic logic [19:0] fetch_rdy(input int xs);
        return ctrl(1, 0, 0, 1, 1, 0, 0, 2, 2, xs, 0, 0, 0);
    endfunction
    function automatic logic [19:0] fetch_wait(input int xs);
        return ctrl(1, 0, 0, 0, 0, 0, 0, 2, 2, xs, 0, 0, 0);
    endfunction
    function automatic logic [19:0] decode_w(input int xs);
        return ctrl(0, 0, 0, 0, 0, 0, 1, 1, 0, xs, 0, 0, 0);
    endfunction
    function automatic logic [19:0] memadr_w(input int xs);
        return ctrl(0, 0, 0, 0, 0, 0, 2, 1, 0, xs, 0, 0, 0);
    endfunction
    function automatic logic [19:0] aluwb_w(input int xs);
        return ctrl(0, 0, 0, 0, 0, 1, 0, 0, 0, xs, 0, 0, 0);
    endfunction

    task automatic chk(input string tag, input logic [19:0] exp_w);
        checks++;
        assert (obs === exp_w) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_w);
        end
    endtask

    // Called at posedge+1: settle, check, then advance to the next posedge+1.
    task automatic cyc(input string tag, input logic [19:0] exp_w);
        #1;
        chk(tag, exp_w);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic rdy);
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.funct7b5  = f7;
        bus.Z         = z;
        bus.mem_ready = rdy;
    endtask

    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int sb, input int alu);
        drive(op, f3, f7, 1'b0, 1'b1);
        cyc({tag, "_fetch"}, fetch_rdy(0));
        cyc({tag, "_decode"}, decode_w(0));
        cyc({tag, "_exec"}, ctrl(0, 0, 0, 0, 0, 0, 2, sb, 0, 0, alu, 0, 0));
        cyc({tag, "_aluwb"}, aluwb_w(0));
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        chk(tag, 20'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(OP_SW, 3'b000, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 20'h0);
        reset = 1'b0;

        run_alu("add", OP_R, 3'b000, 1'b0, 0, 0);
        run_alu("sub", OP_R, 3'b000, 1'b1, 0, 1);
        run_alu("slt", OP_R, 3'b010, 1'b0, 0, 5);
        run_alu("or",  OP_R, 3'b110, 1'b0, 0, 3);
        run_alu("and", OP_R, 3'b111, 1'b0, 0, 2);
        run_alu("addi_f7", OP_I, 3'b000, 1'b1, 1, 0);

        // lw: three wait cycles, ready arrives at the last allowed count
        drive(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        cyc("lw_fetch", fetch_rdy(0));
        cyc("lw_decode", decode_w(0));
        cyc("lw_memadr", memadr_w(0));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_memread_wait", ctrl(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.mem_ready = 1'b1;
        cyc("lw_memread_done", ctrl(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw_memwb", ctrl(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));

        // FETCH after a long MEMREAD must start with a fresh wait count
        drive(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("fetch_wait", fetch_wait(1));
        bus.mem_ready = 1'b1;
        cyc("sw_fetch", fetch_rdy(1));
        cyc("sw_decode", decode_w(1));
        cyc("sw_memadr", memadr_w(1));
        cyc("sw_memwrite", ctrl(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        drive(OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1);
        cyc("beq_t_fetch", fetch_rdy(2));
        cyc("beq_t_decode", decode_w(2));
        cyc("beq_taken", ctrl(0, 0, 0, 0, 1, 0, 2, 0, 0, 2, 1, 0, 0));
        bus.Z = 1'b0;
        cyc("beq_n_fetch", fetch_rdy(2));
        cyc("beq_n_decode", decode_w(2));
        cyc("beq_not_taken", ctrl(0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0, 0));

        drive(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("jal_fetch", fetch_rdy(3));
        cyc("jal_decode", decode_w(3));
        cyc("jal_exec", ctrl(0, 0, 0, 0, 1, 0, 1, 2, 0, 3, 0, 0, 0));
        cyc("jal_aluwb", aluwb_w(3));
        drive(OP_R, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("after_jal_fetch", fetch_rdy(0));

        // Illegal R-type funct3 traps after DECODE
        drive(OP_R, 3'b001, 1'b0, 1'b0, 1'b1);
        cyc("badf3_decode", decode_w(0));
        cyc("badf3_trap", ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        pulse_reset("badf3_reset");

        drive(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b1);
        cyc("badop_fetch", fetch_rdy(0));
        cyc("badop_decode", decode_w(0));
        cyc("badop_trap", ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        bus.mem_ready = 1'b0;
        cyc("badop_trap_held", ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        pulse_reset("badop_reset");

        // Reset in the middle of a store handshake kills dmem_write at once
        drive(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        cyc("sw2_fetch", fetch_rdy(1));
        cyc("sw2_decode", decode_w(1));
        cyc("sw2_memadr", memadr_w(1));
        bus.mem_ready = 1'b0;
        cyc("sw2_memwrite_wait", ctrl(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        pulse_reset("sw2_reset_mid_write");
        cyc("sw2_post_reset_fetch", fetch_wait(1));

        // Bus timeout: counter was cleared by the previous cycle's FETCH entry via reset
        pulse_reset("pre_timeout_reset");
        drive(OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("timeout_req", fetch_wait(0));
        cyc("timeout_trap", ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        bus.mem_ready = 1'b1;
        cyc("timeout_trap_held", ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        pulse_reset("timeout_reset");
        cyc("timeout_recover_fetch", fetch_rdy(0));
        cyc("timeout_recover_decode", decode_w(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
